dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of data and address buses.
REQ-002 Parameter: STARVE_LIMIT, 4, consecutive denied DMA request cycles before DMA is forced a grant.
REQ-003 Parameter: MAX_LOCK, 8, maximum consecutive DMA grant cycles while dma_lock_i is held.
REQ-004 clk  input  1  single system clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 core_req_i / core_we_i  input  1/1  pipeline MEM-stage access request; 1 = store, 0 = load.
REQ-007 core_addr_i / core_wdata_i  input  DATA_WIDTH each  pipeline byte address and store data.
REQ-008 core_gnt_o  output  1  core access is performed this cycle.
REQ-009 core_stall_o  output  1  core_req_i high and not granted; pipeline SHALL hold the MEM stage.
REQ-010 core_rvalid_o / core_rdata_o  output  1/DATA_WIDTH  load response, one cycle after the granted load.
REQ-011 dma_req_i, dma_we_i, dma_lock_i, dma_addr_i, dma_wdata_i  input  1,1,1,DATA_WIDTH,DATA_WIDTH  secondary (loader/DMA) port; lock requests back-to-back ownership.
REQ-012 dma_gnt_o, dma_rvalid_o, dma_rdata_o  output  1,1,DATA_WIDTH  DMA grant and load response.
REQ-013 mem_write_o, mem_read_o  output  1 each  drive Data_Memory Mem_Write_i / Mem_Read_i.
REQ-014 mem_addr_o, mem_wdata_o  output  DATA_WIDTH each  drive Data_Memory Address_i / Write_Data_i.
REQ-015 mem_rdata_i  input  DATA_WIDTH  Data_Memory Read_Data_o (combinational read, zero when read disabled).

Function
REQ-016 At most one of core_gnt_o, dma_gnt_o SHALL be high in any cycle; grants are combinational from requests and registered state.
REQ-017 FSM states CORE_PRI and DMA_LOCK; reset state CORE_PRI.
REQ-018 CORE_PRI: core granted when core_req_i=1 unless starve_cnt = STARVE_LIMIT and dma_req_i=1; otherwise DMA granted if dma_req_i=1.
REQ-019 starve_cnt increments each cycle dma_req_i=1 and DMA is not granted; it clears on any DMA grant or when dma_req_i=0; saturates at STARVE_LIMIT.
REQ-020 CORE_PRI -> DMA_LOCK when DMA is granted with dma_lock_i=1; lock_cnt loads 1.
REQ-021 DMA_LOCK: DMA granted whenever dma_req_i=1, core stalled; lock_cnt increments per DMA grant.
REQ-022 DMA_LOCK -> CORE_PRI when dma_lock_i=0, dma_req_i=0, or lock_cnt = MAX_LOCK (forced release; that cycle's grant still completes).
REQ-023 Granted port's we/addr/wdata SHALL be muxed to mem_*; mem_write_o = granted & we; mem_read_o = granted & ~we.
REQ-024 No grant: mem_write_o=0, mem_read_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-025 Load: mem_rdata_i registered at the grant edge; owner's rvalid_o high exactly the following cycle with that data; other port's rvalid_o=0.
REQ-026 rdata_o outputs SHALL hold last captured value when rvalid_o=0.
REQ-027 Store: completes on the grant edge in Data_Memory; no rvalid pulse.
REQ-028 Addresses passed unchanged; alignment is not checked.

Reset
REQ-029 While reset=1: all grants, stall, rvalid, mem_write_o, mem_read_o = 0; mem_addr_o, mem_wdata_o, rdata_o = 0; starve_cnt, lock_cnt = 0; state CORE_PRI.
REQ-030 Reset asserted mid-lock or with a load in flight SHALL drop the lock and suppress the pending rvalid; no memory write SHALL occur in a reset cycle.

Structure
REQ-031 State encoding, default parameter values and port-select enum SHALL live in a shared package dmem_pkg.
REQ-032 One sub-module: dmem_port_mux (combinational granted-port to mem_* mux); FSM and counters in dmem_arbiter.

Verification
REQ-033 Core-only load addr 0x10 (mem word 4 = 0xCAFE0001) -> core_gnt_o=1 cycle N, core_rvalid_o=1 and core_rdata_o=0xCAFE0001 cycle N+1, no stall.
REQ-034 core_req_i and dma_req_i held continuously -> core granted 4 cycles, DMA granted 5th cycle, pattern repeats; dma_gnt_o never two consecutive cycles.
REQ-035 DMA store stream with dma_lock_i=1, core_req_i=1 -> DMA granted exactly 8 cycles, core_stall_o=1 throughout, then core granted on cycle 9.
REQ-036 Same-cycle core store 0x20=0x11111111 and DMA load 0x20 -> core granted, DMA load next cycle returns 0x11111111.
REQ-037 reset asserted one cycle after a DMA lock grant with a load pending -> dma_rvalid_o=0, state CORE_PRI, mem_write_o=0 during reset.
REQ-038 Every cycle assertion: not (core_gnt_o and dma_gnt_o); mem_read_o and mem_write_o never both high.

Source files
------------

// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared types and defaults for the data-memory arbiter:
//            arbiter state encoding, granted-port select and parameter
//            defaults.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package dmem_pkg;

   localparam int c_def_data_width   = 32;
   localparam int c_def_starve_limit = 4;
   localparam int c_def_max_lock     = 8;

   // Arbiter ownership mode
   typedef enum logic [0:0] {
      CORE_PRI = 1'b0,
      DMA_LOCK = 1'b1
   } arb_state_e;

   // Which requester currently owns the memory port
   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_CORE = 2'd1,
      SEL_DMA  = 2'd2
   } port_sel_e;

endpackage : dmem_pkg

`default_nettype wire

// File: rtl/dmem_port_mux.sv
// ============================================================================
// Module   : dmem_port_mux
// Purpose  : Steers the granted requester's command onto the Data_Memory
//            port; drives an all-zero idle command when nobody is granted.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_port_mux
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH = c_def_data_width
) (
   input  port_sel_e             i_sel,
   input  logic                  i_core_we,
   input  logic [DATA_WIDTH-1:0] i_core_addr,
   input  logic [DATA_WIDTH-1:0] i_core_wdata,
   input  logic                  i_dma_we,
   input  logic [DATA_WIDTH-1:0] i_dma_addr,
   input  logic [DATA_WIDTH-1:0] i_dma_wdata,
   output logic                  o_mem_write,
   output logic                  o_mem_read,
   output logic [DATA_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata
);

   // Route the owner's we/addr/wdata; reads and writes are mutually exclusive
   always_comb begin
      o_mem_write = 1'b0;
      o_mem_read  = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      case (i_sel)
         SEL_CORE: begin
            o_mem_write = i_core_we;
            o_mem_read  = ~i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
         end
         SEL_DMA: begin
            o_mem_write = i_dma_we;
            o_mem_read  = ~i_dma_we;
            o_mem_addr  = i_dma_addr;
            o_mem_wdata = i_dma_wdata;
         end
         default: begin
            o_mem_write = 1'b0;
         end
      endcase
   end

endmodule : dmem_port_mux

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Two-requester arbiter for a single-port data memory. The core
//            pipeline has priority; the DMA/loader port is protected from
//            starvation and may lock the memory for a bounded burst.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH   = c_def_data_width,
   parameter int STARVE_LIMIT = c_def_starve_limit,
   parameter int MAX_LOCK     = c_def_max_lock
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  core_req_i,
   input  logic                  core_we_i,
   input  logic [DATA_WIDTH-1:0] core_addr_i,
   input  logic [DATA_WIDTH-1:0] core_wdata_i,
   output logic                  core_gnt_o,
   output logic                  core_stall_o,
   output logic                  core_rvalid_o,
   output logic [DATA_WIDTH-1:0] core_rdata_o,
   input  logic                  dma_req_i,
   input  logic                  dma_we_i,
   input  logic                  dma_lock_i,
   input  logic [DATA_WIDTH-1:0] dma_addr_i,
   input  logic [DATA_WIDTH-1:0] dma_wdata_i,
   output logic                  dma_gnt_o,
   output logic                  dma_rvalid_o,
   output logic [DATA_WIDTH-1:0] dma_rdata_o,
   output logic                  mem_write_o,
   output logic                  mem_read_o,
   output logic [DATA_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam int c_starve_w = $clog2(STARVE_LIMIT + 1);
   localparam int c_lock_w   = $clog2(MAX_LOCK + 1);
   localparam logic [c_starve_w-1:0] c_starve_max = c_starve_w'(STARVE_LIMIT);
   localparam logic [c_starve_w-1:0] c_starve_one = c_starve_w'(1);
   localparam logic [c_lock_w-1:0]   c_lock_max   = c_lock_w'(MAX_LOCK);
   localparam logic [c_lock_w-1:0]   c_lock_one   = c_lock_w'(1);
   // A one-cycle lock limit is just an ordinary grant, so never enter lock
   localparam bit                    c_lock_allowed = (MAX_LOCK > 1);

   arb_state_e              r_state;
   arb_state_e              w_state_nxt;
   logic [c_starve_w-1:0]   r_starve_cnt;
   logic [c_starve_w-1:0]   w_starve_nxt;
   logic [c_lock_w-1:0]     r_lock_cnt;
   logic [c_lock_w-1:0]     w_lock_nxt;
   logic                    w_core_gnt;
   logic                    w_dma_gnt;
   port_sel_e               w_sel;
   logic                    r_core_rvalid;
   logic                    r_dma_rvalid;
   logic [DATA_WIDTH-1:0]   r_core_rdata;
   logic [DATA_WIDTH-1:0]   r_dma_rdata;

   // Arbiter state and counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= CORE_PRI;
         r_starve_cnt <= '0;
         r_lock_cnt   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_starve_cnt <= w_starve_nxt;
         r_lock_cnt   <= w_lock_nxt;
      end
   end

   // Grant decision, lock entry/exit and starvation tracking
   always_comb begin
      w_core_gnt   = 1'b0;
      w_dma_gnt    = 1'b0;
      w_state_nxt  = r_state;
      w_starve_nxt = r_starve_cnt;
      w_lock_nxt   = r_lock_cnt;
      if (!reset) begin
         case (r_state)
            CORE_PRI: begin
               if (core_req_i && !(dma_req_i && (r_starve_cnt == c_starve_max))) begin
                  w_core_gnt = 1'b1;
               end else if (dma_req_i) begin
                  w_dma_gnt = 1'b1;
               end
               if (w_dma_gnt && dma_lock_i && c_lock_allowed) begin
                  w_state_nxt = DMA_LOCK;
                  w_lock_nxt  = c_lock_one;
               end
            end
            DMA_LOCK: begin
               w_dma_gnt = dma_req_i;
               if (w_dma_gnt) begin
                  w_lock_nxt = r_lock_cnt + c_lock_one;
               end
               // Release after the grant that reaches the limit still completes
               if (!dma_lock_i || !dma_req_i || ((r_lock_cnt + c_lock_one) >= c_lock_max)) begin
                  w_state_nxt = CORE_PRI;
                  w_lock_nxt  = '0;
               end
            end
            default: begin
               w_state_nxt = CORE_PRI;
               w_lock_nxt  = '0;
            end
         endcase
         if (w_dma_gnt || !dma_req_i) begin
            w_starve_nxt = '0;
         end else if (r_starve_cnt != c_starve_max) begin
            w_starve_nxt = r_starve_cnt + c_starve_one;
         end
      end
   end

   // Load responses: capture read data at the grant edge, pulse owner's rvalid
   always_ff @(posedge clk) begin
      if (reset) begin
         r_core_rvalid <= 1'b0;
         r_dma_rvalid  <= 1'b0;
         r_core_rdata  <= '0;
         r_dma_rdata   <= '0;
      end else begin
         r_core_rvalid <= w_core_gnt & ~core_we_i;
         r_dma_rvalid  <= w_dma_gnt & ~dma_we_i;
         if (w_core_gnt && !core_we_i) begin
            r_core_rdata <= mem_rdata_i;
         end
         if (w_dma_gnt && !dma_we_i) begin
            r_dma_rdata <= mem_rdata_i;
         end
      end
   end

   assign w_sel = w_core_gnt ? SEL_CORE : (w_dma_gnt ? SEL_DMA : SEL_NONE);

   dmem_port_mux #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_port_mux (
      .i_sel        (w_sel),
      .i_core_we    (core_we_i),
      .i_core_addr  (core_addr_i),
      .i_core_wdata (core_wdata_i),
      .i_dma_we     (dma_we_i),
      .i_dma_addr   (dma_addr_i),
      .i_dma_wdata  (dma_wdata_i),
      .o_mem_write  (mem_write_o),
      .o_mem_read   (mem_read_o),
      .o_mem_addr   (mem_addr_o),
      .o_mem_wdata  (mem_wdata_o)
   );

   assign core_gnt_o    = w_core_gnt;
   assign dma_gnt_o     = w_dma_gnt;
   assign core_stall_o  = core_req_i & ~w_core_gnt & ~reset;
   // A response pending when reset arrives is dropped immediately
   assign core_rvalid_o = r_core_rvalid & ~reset;
   assign dma_rvalid_o  = r_dma_rvalid & ~reset;
   assign core_rdata_o  = reset ? '0 : r_core_rdata;
   assign dma_rdata_o   = reset ? '0 : r_dma_rdata;

endmodule : dmem_arbiter

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Self-checking bench for dmem_arbiter with a Data_Memory model,
//            directed scenarios and randomized traffic against a
//            behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_dmem_arbiter;

   localparam int DW = 32;
   localparam int SL = 4;
   localparam int ML = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          core_req_i, core_we_i;
   logic [DW-1:0] core_addr_i, core_wdata_i;
   logic          core_gnt_o, core_stall_o, core_rvalid_o;
   logic [DW-1:0] core_rdata_o;
   logic          dma_req_i, dma_we_i, dma_lock_i;
   logic [DW-1:0] dma_addr_i, dma_wdata_i;
   logic          dma_gnt_o, dma_rvalid_o;
   logic [DW-1:0] dma_rdata_o;
   logic          mem_write_o, mem_read_o;
   logic [DW-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

   // Data_Memory stand-in and the reference copy the model predicts from
   logic [DW-1:0] mem     [0:63];
   logic [DW-1:0] ref_mem [0:63];

   int errors = 0;
   int checks = 0;

   // Reference model state
   int            m_denied;
   bit            m_lock;
   int            m_lock_grants;
   bit            m_pend_core, m_pend_dma;
   logic [DW-1:0] m_core_data, m_dma_data;

   // Observed grant statistics for directed scenarios
   int n_core_gnt, n_dma_gnt, n_dma_b2b, n_stall, dma_run, max_dma_run;
   bit last_dma;

   dmem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(SL), .MAX_LOCK(ML)) dut (
      .clk           (clk),
      .reset         (reset),
      .core_req_i    (core_req_i),
      .core_we_i     (core_we_i),
      .core_addr_i   (core_addr_i),
      .core_wdata_i  (core_wdata_i),
      .core_gnt_o    (core_gnt_o),
      .core_stall_o  (core_stall_o),
      .core_rvalid_o (core_rvalid_o),
      .core_rdata_o  (core_rdata_o),
      .dma_req_i     (dma_req_i),
      .dma_we_i      (dma_we_i),
      .dma_lock_i    (dma_lock_i),
      .dma_addr_i    (dma_addr_i),
      .dma_wdata_i   (dma_wdata_i),
      .dma_gnt_o     (dma_gnt_o),
      .dma_rvalid_o  (dma_rvalid_o),
      .dma_rdata_o   (dma_rdata_o),
      .mem_write_o   (mem_write_o),
      .mem_read_o    (mem_read_o),
      .mem_addr_o    (mem_addr_o),
      .mem_wdata_o   (mem_wdata_o),
      .mem_rdata_i   (mem_rdata_i)
   );

   always #5 clk = ~clk;

   assign mem_rdata_i = mem_read_o ? mem[mem_addr_o[7:2]] : '0;

   // Memory write on the grant edge
   always @(posedge clk) begin
      if (mem_write_o) mem[mem_addr_o[7:2]] = mem_wdata_o;
   end

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic clear_stats();
      n_core_gnt = 0; n_dma_gnt = 0; n_dma_b2b = 0; n_stall = 0;
      dma_run = 0; max_dma_run = 0; last_dma = 0;
   endtask

   // Predict this cycle's outputs, compare, then advance the model
   task automatic check_cycle();
      bit            e_core, e_dma, force_dma, e_wr, e_rd;
      logic [DW-1:0] e_addr, e_wdata;
      e_core = 0; e_dma = 0; force_dma = 0;
      if (!reset) begin
         if (m_lock) begin
            e_dma = dma_req_i;
         end else begin
            force_dma = dma_req_i && (m_denied >= SL);
            e_core    = core_req_i && !force_dma;
            e_dma     = dma_req_i && !e_core;
         end
      end
      e_wr = 0; e_rd = 0; e_addr = '0; e_wdata = '0;
      if (e_core) begin
         e_wr = core_we_i; e_rd = !core_we_i; e_addr = core_addr_i; e_wdata = core_wdata_i;
      end else if (e_dma) begin
         e_wr = dma_we_i; e_rd = !dma_we_i; e_addr = dma_addr_i; e_wdata = dma_wdata_i;
      end

      chk("core_gnt",    core_gnt_o,   e_core);
      chk("dma_gnt",     dma_gnt_o,    e_dma);
      chk("core_stall",  core_stall_o, !reset && core_req_i && !e_core);
      chk("gnt_mutex",   core_gnt_o & dma_gnt_o, 0);
      chk("rd_wr_excl",  mem_read_o & mem_write_o, 0);
      chk("mem_write",   mem_write_o,  e_wr);
      chk("mem_read",    mem_read_o,   e_rd);
      chk("mem_addr",    mem_addr_o,   e_addr);
      chk("mem_wdata",   mem_wdata_o,  e_wdata);
      chk("core_rvalid", core_rvalid_o, !reset && m_pend_core);
      chk("core_rdata",  core_rdata_o, reset ? '0 : m_core_data);
      chk("dma_rvalid",  dma_rvalid_o, !reset && m_pend_dma);
      chk("dma_rdata",   dma_rdata_o,  reset ? '0 : m_dma_data);

      if (core_gnt_o) n_core_gnt++;
      if (core_stall_o) n_stall++;
      if (dma_gnt_o) begin
         n_dma_gnt++;
         if (last_dma) n_dma_b2b++;
         dma_run++;
         if (dma_run > max_dma_run) max_dma_run = dma_run;
      end else begin
         dma_run = 0;
      end
      last_dma = dma_gnt_o;

      if (reset) begin
         m_lock = 0; m_denied = 0; m_lock_grants = 0;
         m_pend_core = 0; m_pend_dma = 0; m_core_data = '0; m_dma_data = '0;
      end else begin
         m_pend_core = e_core && !core_we_i;
         m_pend_dma  = e_dma && !dma_we_i;
         if (m_pend_core) m_core_data = ref_mem[core_addr_i[7:2]];
         if (m_pend_dma)  m_dma_data  = ref_mem[dma_addr_i[7:2]];
         if (e_wr) ref_mem[e_addr[7:2]] = e_wdata;
         if (dma_req_i && !e_dma) m_denied = (m_denied < SL) ? m_denied + 1 : SL;
         else m_denied = 0;
         if (!m_lock) begin
            if (e_dma && dma_lock_i) begin
               m_lock = 1; m_lock_grants = 1;
            end
         end else begin
            if (e_dma) m_lock_grants++;
            if (!dma_lock_i || !dma_req_i || m_lock_grants >= ML) m_lock = 0;
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      core_req_i = 0; core_we_i = 0; core_addr_i = '0; core_wdata_i = '0;
      dma_req_i = 0; dma_we_i = 0; dma_lock_i = 0; dma_addr_i = '0; dma_wdata_i = '0;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         mem[i] = $urandom;
         ref_mem[i] = mem[i];
      end
      mem[4] = 32'hCAFE0001;
      ref_mem[4] = 32'hCAFE0001;
      m_denied = 0; m_lock = 0; m_lock_grants = 0;
      m_pend_core = 0; m_pend_dma = 0; m_core_data = '0; m_dma_data = '0;
      clear_stats();
      idle();
      reset = 1;
      repeat (3) cycle();
      reset = 0;
      cycle();

      // Core-only load from word 4
      core_req_i = 1; core_we_i = 0; core_addr_i = 32'h10;
      #1;
      chk("r33_gnt", core_gnt_o, 1);
      chk("r33_stall", core_stall_o, 0);
      cycle();
      idle();
      chk("r33_rvalid", core_rvalid_o, 1);
      chk("r33_rdata", core_rdata_o, 32'hCAFE0001);
      chk("r33_dma_rvalid", dma_rvalid_o, 0);
      cycle();

      // Continuous contention without lock: 4 core grants, then 1 DMA grant
      clear_stats();
      core_req_i = 1; core_we_i = 1; core_addr_i = 32'h40; core_wdata_i = $urandom;
      dma_req_i = 1; dma_we_i = 1; dma_addr_i = 32'h44; dma_wdata_i = $urandom;
      repeat (20) cycle();
      chk("r34_dma_cnt", n_dma_gnt, 4);
      chk("r34_core_cnt", n_core_gnt, 16);
      chk("r34_dma_b2b", n_dma_b2b, 0);
      idle();
      cycle();

      // Locked DMA store burst under core pressure
      clear_stats();
      core_req_i = 1; core_we_i = 1; core_addr_i = 32'h48; core_wdata_i = $urandom;
      dma_req_i = 1; dma_we_i = 1; dma_lock_i = 1; dma_addr_i = 32'h4C; dma_wdata_i = $urandom;
      repeat (12) cycle();
      chk("r35_dma_cnt", n_dma_gnt, 8);
      chk("r35_dma_run", max_dma_run, 8);
      chk("r35_stall_cnt", n_stall, 8);
      chk("r35_core_after", core_gnt_o, 1);
      cycle();
      chk("r35_core_cnt", n_core_gnt, 5);
      idle();
      cycle();

      // Same-cycle core store and DMA load to the same address
      core_req_i = 1; core_we_i = 1; core_addr_i = 32'h20; core_wdata_i = 32'h11111111;
      dma_req_i = 1; dma_we_i = 0; dma_addr_i = 32'h20;
      #1;
      chk("r36_core_first", core_gnt_o, 1);
      cycle();
      core_req_i = 0; core_we_i = 0;
      cycle();
      idle();
      chk("r36_rvalid", dma_rvalid_o, 1);
      chk("r36_rdata", dma_rdata_o, 32'h11111111);
      cycle();

      // Reset arriving with a locked DMA load response in flight
      dma_req_i = 1; dma_we_i = 0; dma_lock_i = 1; dma_addr_i = 32'h10;
      cycle();
      reset = 1;
      core_req_i = 1; core_we_i = 1; core_addr_i = 32'h24; core_wdata_i = 32'hDEADBEEF;
      #1;
      chk("r37_rvalid", dma_rvalid_o, 0);
      chk("r37_dma_gnt", dma_gnt_o, 0);
      chk("r37_mem_write", mem_write_o, 0);
      cycle();
      reset = 0;
      core_we_i = 0; core_addr_i = 32'h14;
      #1;
      chk("r37_core_pri", core_gnt_o, 1);
      cycle();
      idle();
      cycle();

      // Randomized traffic with sticky DMA request/lock to reach long bursts
      for (int n = 0; n < 800; n++) begin
         reset        = ($urandom_range(0, 59) == 0);
         core_req_i   = ($urandom_range(0, 9) < 6);
         core_we_i    = $urandom_range(0, 1);
         core_addr_i  = 32'($urandom_range(0, 255));
         core_wdata_i = $urandom;
         if ($urandom_range(0, 6) == 0) dma_req_i = ~dma_req_i;
         if ($urandom_range(0, 6) == 0) dma_lock_i = ~dma_lock_i;
         dma_we_i     = $urandom_range(0, 1);
         dma_addr_i   = 32'($urandom_range(0, 255));
         dma_wdata_i  = $urandom;
         cycle();
      end
      reset = 0;
      idle();
      cycle();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_dmem_arbiter

`default_nettype wire
